// File: rtl/complex_mult_scheduler_pkg.sv
// Shared widths, FSM encodings and width helpers for the complex-multiplier scheduler.
package cmplx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int OP_W       = 4 * DATA_WIDTH;
  localparam int RES_W      = 4 * DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } sched_state_e;

  function automatic int op_width(input int dw);
    return 4 * dw;
  endfunction

  function automatic int res_width(input int dw);
    return 4 * dw + 3;
  endfunction

endpackage

// File: rtl/complex_mult_scheduler_rr_ptr.sv
// Wrapping round-robin pointer with increment enable and synchronous clear.
module rr_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Instance count is a power of two, so natural overflow is the wrap.
  always_comb begin
    if (inc) begin
      ptr_d = ptr_q + W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/complex_mult_scheduler.sv
// Round-robin scheduler sharing NUM_INST complex multipliers between one operand
// stream and one in-order result stream, with a drain/enable control FSM.
module complex_mult_scheduler
  import cmplx_pkg::*;
#(
  parameter int DATA_WIDTH = cmplx_pkg::DATA_WIDTH,
  parameter int NUM_INST   = 4,
  localparam int PTR_W     = $clog2(NUM_INST)
) (
  input  logic                                clk,
  input  logic                                sw_rst,
  input  logic                                en,
  input  logic                                drain_req,
  output logic                                drain_done,
  output logic [PTR_W:0]                      inflight,
  input  logic                                op_val,
  output logic                                op_ready,
  input  logic [4*DATA_WIDTH-1:0]             op_data,
  output logic [NUM_INST-1:0]                 inst_op_val,
  input  logic [NUM_INST-1:0]                 inst_op_ready,
  output logic [4*DATA_WIDTH-1:0]             inst_op_data,
  input  logic [NUM_INST-1:0]                 inst_res_val,
  output logic [NUM_INST-1:0]                 inst_res_ready,
  input  logic [NUM_INST*(4*DATA_WIDTH+3)-1:0] inst_res_data,
  output logic                                res_val,
  input  logic                                res_ready,
  output logic [4*DATA_WIDTH+2:0]             res_data
);

  localparam int RESW = res_width(DATA_WIDTH);

  sched_state_e         state_q, state_d;
  logic [NUM_INST-1:0]  busy_q, busy_d;
  logic [PTR_W:0]       inflight_q, inflight_d;
  logic                 drain_done_q, drain_done_d;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 can_issue;
  logic                 issue;
  logic                 retire;

  rr_ptr #(.W(PTR_W)) u_wr_ptr (.clk(clk), .clr(sw_rst), .inc(issue),  .ptr(wr_ptr));
  rr_ptr #(.W(PTR_W)) u_rd_ptr (.clk(clk), .clr(sw_rst), .inc(retire), .ptr(rd_ptr));

  assign inst_op_data = op_data;

  // Handshakes are held low during reset since instances are being cleared too.
  always_comb begin
    can_issue = ~sw_rst & (state_q == ST_RUN) & en & ~busy_q[wr_ptr];
    op_ready  = can_issue & inst_op_ready[wr_ptr];
    inst_op_val         = '0;
    inst_op_val[wr_ptr] = can_issue & op_val;
    res_val   = ~sw_rst & busy_q[rd_ptr] & inst_res_val[rd_ptr];
    inst_res_ready         = '0;
    inst_res_ready[rd_ptr] = ~sw_rst & busy_q[rd_ptr] & res_ready;
    res_data  = inst_res_data[int'(rd_ptr)*RESW +: RESW];
    issue     = op_val & op_ready;
    retire    = res_val & res_ready;
  end

  // Issue and retire never target the same instance: one needs it idle, the other busy.
  always_comb begin
    busy_d = busy_q;
    if (issue) begin
      busy_d[wr_ptr] = 1'b1;
    end else begin
      busy_d[wr_ptr] = busy_q[wr_ptr];
    end
    if (retire) begin
      busy_d[rd_ptr] = 1'b0;
    end else begin
      busy_d[rd_ptr] = busy_d[rd_ptr];
    end
    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + (PTR_W+1)'(1);
      2'b01:   inflight_d = inflight_q - (PTR_W+1)'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAIN;
        else           state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (inflight_q == '0) state_d = ST_DRAINED;
        else if (!drain_req)  state_d = ST_RUN;
        else                  state_d = ST_DRAIN;
      end
      ST_DRAINED: begin
        if (!drain_req) state_d = ST_RUN;
        else            state_d = ST_DRAINED;
      end
      default: state_d = ST_RUN;
    endcase
    drain_done_d = (state_d == ST_DRAINED);
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q      <= ST_RUN;
      busy_q       <= '0;
      inflight_q   <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      inflight_q   <= inflight_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign drain_done = drain_done_q;
  assign inflight   = inflight_q;

endmodule

// File: tb/tb_complex_mult_scheduler.sv
// Self-checking bench: behavioural multiplier instances, a queue-based scoreboard
// monitor, and one task per scenario with inline checks.
module tb_complex_mult_scheduler;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int RW = 4*DW+3;

  logic            clk = 1'b0;
  logic            sw_rst, en, drain_req, drain_done;
  logic [2:0]      inflight;
  logic            op_val, op_ready;
  logic [4*DW-1:0] op_data;
  logic [N-1:0]    inst_op_val, inst_op_ready;
  logic [4*DW-1:0] inst_op_data;
  logic [N-1:0]    inst_res_val, inst_res_ready;
  logic [N*RW-1:0] inst_res_data;
  logic            res_val, res_ready;
  logic [RW-1:0]   res_data;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  complex_mult_scheduler #(.DATA_WIDTH(DW), .NUM_INST(N)) dut (
    .clk(clk), .sw_rst(sw_rst), .en(en), .drain_req(drain_req),
    .drain_done(drain_done), .inflight(inflight),
    .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
    .inst_op_val(inst_op_val), .inst_op_ready(inst_op_ready), .inst_op_data(inst_op_data),
    .inst_res_val(inst_res_val), .inst_res_ready(inst_res_ready), .inst_res_data(inst_res_data),
    .res_val(res_val), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // {re (18b signed), im (17b signed)} of (a_re + j a_im) * (b_re + j b_im)
  function automatic logic [RW-1:0] cprod(input logic [4*DW-1:0] d);
    int ar, ai, br, bi, re, im;
    logic [17:0] re_v;
    logic [16:0] im_v;
    ar = int'($signed(d[31:24])); ai = int'($signed(d[23:16]));
    br = int'($signed(d[15:8]));  bi = int'($signed(d[7:0]));
    re = ar*br - ai*bi;
    im = ar*bi + ai*br;
    re_v = re[17:0];
    im_v = im[16:0];
    return {re_v, im_v};
  endfunction

  // ---------------- behavioural multiplier instances ----------------
  int           lat [N];
  int           cnt [N];
  logic [RW-1:0] rdat [N];
  logic [N-1:0] occ = '0;
  logic [N-1:0] ready_mask;
  logic [N-1:0] spur;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      inst_op_ready[i] = ready_mask[i] & ~occ[i];
      inst_res_val[i]  = spur[i] | (occ[i] & (cnt[i] == 0));
      inst_res_data[i*RW +: RW] = rdat[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (sw_rst) begin
        occ[i] <= 1'b0;
      end else if (inst_op_val[i] && inst_op_ready[i]) begin
        occ[i]  <= 1'b1;
        cnt[i]  <= lat[i] - 1;
        rdat[i] <= cprod(inst_op_data);
      end else if (occ[i]) begin
        if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
        else if (inst_res_ready[i]) occ[i] <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  // Outstanding work is a FIFO of expected products; instance i is busy iff it lies
  // within the first size() slots counted round-robin from the head instance m_rd.
  logic [RW-1:0] sbq[$];
  int m_rd = 0;
  int m_state = 0;  // 0 run, 1 draining, 2 drained

  function automatic bit mbusy(input int i);
    return ((i - m_rd + N) % N) < sbq.size();
  endfunction

  always @(negedge clk) begin
    int cur, wr, nxt;
    bit e_rdy, e_rv, iss, ret;
    logic [N-1:0] e_iov, e_irr;
    cur = sbq.size();
    wr  = (m_rd + cur) % N;
    e_rdy = !sw_rst && m_state == 0 && en && !mbusy(wr) && inst_op_ready[wr];
    e_iov = '0;
    if (!sw_rst && m_state == 0 && en && !mbusy(wr) && op_val) e_iov[wr] = 1'b1;
    e_rv  = !sw_rst && mbusy(m_rd) && inst_res_val[m_rd];
    e_irr = '0;
    if (!sw_rst && mbusy(m_rd) && res_ready) e_irr[m_rd] = 1'b1;
    if (mon_on) begin
      checks++;
      if (op_ready !== e_rdy) begin errors++; $display("FAIL mon_op_ready: got %0b expected %0b at %0t", op_ready, e_rdy, $time); end
      checks++;
      if (inst_op_val !== e_iov) begin errors++; $display("FAIL mon_inst_op_val: got %b expected %b at %0t", inst_op_val, e_iov, $time); end
      checks++;
      if (inst_op_data !== op_data) begin errors++; $display("FAIL mon_inst_op_data: got %h expected %h at %0t", inst_op_data, op_data, $time); end
      checks++;
      if (res_val !== e_rv) begin errors++; $display("FAIL mon_res_val: got %0b expected %0b at %0t", res_val, e_rv, $time); end
      checks++;
      if (inst_res_ready !== e_irr) begin errors++; $display("FAIL mon_inst_res_ready: got %b expected %b at %0t", inst_res_ready, e_irr, $time); end
      checks++;
      if (inflight !== 3'(cur)) begin errors++; $display("FAIL mon_inflight: got %0d expected %0d at %0t", inflight, cur, $time); end
      checks++;
      if (drain_done !== (m_state == 2)) begin errors++; $display("FAIL mon_drain_done: got %0b expected %0b at %0t", drain_done, (m_state == 2), $time); end
      if (e_rv && cur > 0) begin
        checks++;
        if (res_data !== sbq[0]) begin errors++; $display("FAIL mon_res_data: got %h expected %h at %0t", res_data, sbq[0], $time); end
      end
    end
    if (sw_rst) begin
      sbq.delete();
      m_rd = 0;
      m_state = 0;
    end else begin
      iss = op_val && e_rdy;
      ret = e_rv && res_ready;
      nxt = m_state;
      if (m_state == 0 && drain_req) nxt = 1;
      else if (m_state == 1 && cur == 0) nxt = 2;
      else if (m_state == 1 && !drain_req) nxt = 0;
      else if (m_state == 2 && !drain_req) nxt = 0;
      m_state = nxt;
      if (ret && cur > 0) begin
        void'(sbq.pop_front());
        m_rd = (m_rd + 1) % N;
      end
      if (iss) sbq.push_back(cprod(op_data));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    sw_rst = 1'b1; op_val = 1'b0; drain_req = 1'b0; en = 1'b1;
    tick();
    sw_rst = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int bound);
    bit done = 1'b0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clk);
      if (inflight == 3'd0) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s_timeout: inflight %0d, required 0", name, inflight); end
    tick();
  endtask

  task automatic issue_n(input int n);
    for (int j = 0; j < n; j++) begin
      op_data = $urandom; op_val = 1'b1;
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %0b expected 1 (op %0d)", op_ready, j); end
      tick();
    end
    op_val = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sw_rst = 1'b1; en = 1'b1; op_val = 1'b1; res_ready = 1'b1; spur = '1; op_data = 32'h01020304;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({op_ready, inst_op_val, inst_res_ready, res_val} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs: got %b expected all zero", {op_ready, inst_op_val, inst_res_ready, res_val});
    end
    tick();
    sw_rst = 1'b0; op_val = 1'b0; spur = '0; res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (inflight !== 3'd0 || drain_done !== 1'b0 || res_val !== 1'b0) begin
      errors++; $display("FAIL reset_state: inflight %0d drain_done %0b res_val %0b, required 0 0 0", inflight, drain_done, res_val);
    end
    mon_on = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    bit seen = 1'b0;
    apply_reset();
    for (int i = 0; i < N; i++) lat[i] = 1;
    op_data = {8'd5, 8'd2, 8'd3, 8'd1}; op_val = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_op_val !== 4'b0001 || op_ready !== 1'b1) begin errors++; $display("FAIL single_issue: inst_op_val %b op_ready %0b, required 0001 1", inst_op_val, op_ready); end
    tick();
    op_val = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (res_val) seen = 1'b1;
    end
    checks++;
    if (!seen || $signed(res_data[34:17]) != 13 || $signed(res_data[16:0]) != 11) begin
      errors++; $display("FAIL single_result: valid %0b re %0d im %0d, required 1 13 11", seen, $signed(res_data[34:17]), $signed(res_data[16:0]));
    end
    tick();
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (inflight !== 3'd0) begin errors++; $display("FAIL single_inflight: got %0d expected 0", inflight); end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_burst();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    int nres = 0;
    bit got;
    apply_reset();
    lat[0] = 1; lat[1] = 4; lat[2] = 2; lat[3] = 3;
    res_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      op_data = $urandom; op_val = 1'b1; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (res_val) nres++;
        if (op_ready) got = 1'b1;
      end
      checks++;
      if (!got || inst_op_val !== 4'(1 << order[j])) begin
        errors++; $display("FAIL burst_order: op %0d inst_op_val %b, required one-hot %0d", j, inst_op_val, order[j]);
      end
      tick();
    end
    op_val = 1'b0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (res_val) nres++;
      if (inflight == 3'd0) got = 1'b1;
    end
    checks++;
    if (nres != 6) begin errors++; $display("FAIL burst_count: got %0d results expected 6", nres); end
    tick();
  endtask

  task automatic test_full();
    int acc = 0;
    apply_reset();
    for (int i = 0; i < N; i++) lat[i] = 1;
    res_ready = 1'b0; op_val = 1'b1; op_data = $urandom;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (op_ready) acc++;
      tick();
      op_data = $urandom;
    end
    @(negedge clk);
    checks++;
    if (acc != 4 || op_ready !== 1'b0 || inflight !== 3'd4) begin
      errors++; $display("FAIL full_state: accepted %0d op_ready %0b inflight %0d, required 4 0 4", acc, op_ready, inflight);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_val !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: res_val %0b op_ready %0b, required 1 0", res_val, op_ready); end
    tick();
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1 || inflight !== 3'd3) begin errors++; $display("FAIL full_fifth: op_ready %0b inflight %0d, required 1 3", op_ready, inflight); end
    tick();
    op_val = 1'b0;
    wait_empty("full", 20);
  endtask

  task automatic test_drain();
    int nres = 0, k_ret = -1, k_done = -1;
    apply_reset();
    for (int i = 0; i < N; i++) lat[i] = 3;
    res_ready = 1'b0;
    issue_n(3);
    drain_req = 1'b1;
    tick();
    op_val = 1'b1; op_data = $urandom;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b0 || inst_op_val !== 4'b0000) begin errors++; $display("FAIL drain_block: op_ready %0b inst_op_val %b, required 0 0000", op_ready, inst_op_val); end
    tick();
    res_ready = 1'b1;
    for (int k = 0; k < 30 && k_done < 0; k++) begin
      @(negedge clk);
      if (res_val) begin nres++; if (nres == 3) k_ret = k; end
      if (drain_done) k_done = k;
    end
    checks++;
    if (nres != 3 || k_done - k_ret != 2 || inflight !== 3'd0) begin
      errors++; $display("FAIL drain_done_timing: retires %0d done-after %0d inflight %0d, required 3 2 0", nres, k_done - k_ret, inflight);
    end
    tick();
    drain_req = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (drain_done !== 1'b0 || inst_op_val !== 4'b1000 || op_ready !== 1'b1) begin
      errors++; $display("FAIL drain_resume: drain_done %0b inst_op_val %b op_ready %0b, required 0 1000 1", drain_done, inst_op_val, op_ready);
    end
    tick();
    op_val = 1'b0;
    wait_empty("drain", 20);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < N; i++) lat[i] = 8;
    res_ready = 1'b0;
    issue_n(2);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0; op_val = 1'b1; op_data = $urandom;
    @(negedge clk);
    checks++;
    if (inflight !== 3'd0 || res_val !== 1'b0 || drain_done !== 1'b0 || inst_op_val !== 4'b0001) begin
      errors++; $display("FAIL reset_mid: inflight %0d res_val %0b drain_done %0b inst_op_val %b, required 0 0 0 0001", inflight, res_val, drain_done, inst_op_val);
    end
    tick();
    op_val = 1'b0; res_ready = 1'b1;
    wait_empty("reset_mid", 20);
  endtask

  task automatic test_en_backpressure();
    int nres = 0;
    apply_reset();
    for (int i = 0; i < N; i++) lat[i] = 2;
    res_ready = 1'b0;
    issue_n(2);
    op_val = 1'b1; en = 1'b0; res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_val) nres++;
      checks++;
      if (inst_op_val !== 4'b0000 || op_ready !== 1'b0) begin errors++; $display("FAIL en_block: cycle %0d inst_op_val %b op_ready %0b, required 0000 0", k, inst_op_val, op_ready); end
    end
    checks++;
    if (nres != 2 || inflight !== 3'd0) begin errors++; $display("FAIL en_retire: results %0d inflight %0d, required 2 0", nres, inflight); end
    tick();
    en = 1'b1; ready_mask = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (op_ready !== 1'b0 || inst_op_val !== 4'b0100) begin errors++; $display("FAIL inst_backpressure: op_ready %0b inst_op_val %b, required 0 0100", op_ready, inst_op_val); end
      tick();
    end
    ready_mask = '1;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1 || inst_op_val !== 4'b0100) begin errors++; $display("FAIL backpressure_release: op_ready %0b inst_op_val %b, required 1 0100", op_ready, inst_op_val); end
    tick();
    op_val = 1'b0;
    wait_empty("en", 20);
  endtask

  task automatic test_spurious();
    apply_reset();
    spur = '1; res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (res_val !== 1'b0 || inst_res_ready !== 4'b0000) begin errors++; $display("FAIL spurious: res_val %0b inst_res_ready %b, required 0 0000", res_val, inst_res_ready); end
    end
    tick();
    spur = '0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 5);
    for (int c = 0; c < 600; c++) begin
      tick();
      op_val    = ($urandom_range(0, 9) < 6);
      op_data   = $urandom;
      res_ready = ($urandom_range(0, 9) < 7);
      en        = ($urandom_range(0, 9) < 9);
      if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
      for (int i = 0; i < N; i++) ready_mask[i] = ($urandom_range(0, 9) < 9);
    end
    tick();
    drain_req = 1'b0; en = 1'b1; op_val = 1'b0; res_ready = 1'b1; ready_mask = '1;
    wait_empty("random", 60);
  endtask

  initial begin
    sw_rst = 1'b1; en = 1'b1; drain_req = 1'b0; op_val = 1'b0; op_data = '0;
    res_ready = 1'b0; ready_mask = '1; spur = '0;
    for (int i = 0; i < N; i++) begin lat[i] = 1; cnt[i] = 0; rdat[i] = '0; end
    test_reset();
    test_single_op();
    test_burst();
    test_full();
    test_drain();
    test_reset_mid();
    test_en_backpressure();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
